ysyx_041461_pipe_ctrl: RTL and testbench

- Pipeline valid/stall/flush controller for the six-stage core (IF, IF2, ID, EXE, MEM, WB).
- Consumes the per-stage conflict and trap flags from the conflict detector, plus MEM busy, ID redirect and WB trap-commit.
- Produces the stage valid bits fed back to the detector, per-stage pipe-register load enables, the fetch enable and a one-cycle trap-redirect pulse.
- Runs a RUN/DRAIN/REDIRECT trap-drain state machine and a saturating stall-cycle counter.

---
 rtl/ysyx_041461_pipe_ctrl.sv | 154 +++++++++++++++
 tb/tb_ysyx_041461_pipe_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_041461_pipe_ctrl.sv
// Valid/stall/flush control for the six-stage pipeline (IF, IF2, ID, EXE, MEM, WB).
// Builds the stall chain and load enables, runs the trap-drain FSM and counts RUN-state ID stalls.
module ysyx_041461_pipe_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             if_ready,
   input  logic             mem_ready,
   input  logic             id_conflict,
   input  logic             exe_conflict,
   input  logic             mem_conflict,
   input  logic             if_kill,
   input  logic             if2_kill,
   input  logic             id_kill,
   input  logic             exe_kill,
   input  logic             mem_kill,
   input  logic             id_redirect,
   input  logic             wb_trap_commit,
   output logic             v_if2,
   output logic             v_id,
   output logic             v_exe,
   output logic             v_mem,
   output logic             v_wb,
   output logic             en_if,
   output logic             en_if2,
   output logic             en_id,
   output logic             en_exe,
   output logic             en_mem,
   output logic             trap_redirect,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      S_RUN      = 2'd0,
      S_DRAIN    = 2'd1,
      S_REDIRECT = 2'd2
   } state_e;

   state_e           r_state;
   state_e           w_state_next;
   logic             r_v_if2, r_v_id, r_v_exe, r_v_mem, r_v_wb;
   logic             r_trap_redirect;
   logic [CNT_W-1:0] r_stall_cnt;

   logic w_stall_mem, w_stall_exe, w_stall_id, w_stall_if2, w_stall_if;
   logic w_redirect_fire;
   logic w_fetch_ok, w_flush;
   logic w_v_if2_nxt, w_v_id_nxt, w_v_exe_nxt, w_v_mem_nxt, w_v_wb_nxt;

   // A stall anywhere downstream freezes every stage above it.
   assign w_stall_mem = r_v_mem & (mem_conflict | ~mem_ready);
   assign w_stall_exe = (r_v_exe & exe_conflict) | w_stall_mem;
   assign w_stall_id  = (r_v_id & id_conflict) | w_stall_exe;
   assign w_stall_if2 = w_stall_id;
   assign w_stall_if  = w_stall_if2;

   assign en_if  = ~w_stall_if & w_fetch_ok & ~if_kill;
   assign en_if2 = ~w_stall_if2;
   assign en_id  = ~w_stall_id;
   assign en_exe = ~w_stall_exe;
   assign en_mem = ~w_stall_mem;

   assign w_redirect_fire = id_redirect & r_v_id & ~w_stall_id & ~id_kill;

   // FSM: state register
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= S_RUN;
         r_trap_redirect <= 1'b0;
      end else begin
         r_state         <= w_state_next;
         r_trap_redirect <= (w_state_next == S_REDIRECT);
      end
   end

   // FSM: next state; a commit in RUN means the trap entered and retired together.
   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         S_RUN: begin
            if (wb_trap_commit)  w_state_next = S_REDIRECT;
            else if (if_kill)    w_state_next = S_DRAIN;
         end
         S_DRAIN:    if (wb_trap_commit) w_state_next = S_REDIRECT;
         S_REDIRECT: w_state_next = S_RUN;
         default:    w_state_next = S_RUN;
      endcase
   end

   // FSM: outputs
   always_comb begin
      w_fetch_ok = 1'b0;
      w_flush    = 1'b0;
      unique case (r_state)
         S_RUN:      w_fetch_ok = 1'b1;
         S_REDIRECT: w_flush    = 1'b1;
         default:    ;
      endcase
   end

   // Stalled stages hold (kill still drops them); free stages take the upstream valid.
   always_comb begin
      w_v_if2_nxt = w_stall_if2 ? (r_v_if2 & ~if2_kill)
                                : (if_ready & en_if & ~w_redirect_fire & ~w_stall_if & ~if_kill);
      w_v_id_nxt  = w_stall_id  ? (r_v_id & ~id_kill)
                                : (r_v_if2 & ~w_stall_if2 & ~if2_kill & ~w_redirect_fire);
      w_v_exe_nxt = w_stall_exe ? (r_v_exe & ~exe_kill)
                                : (r_v_id & ~w_stall_id & ~id_kill);
      w_v_mem_nxt = w_stall_mem ? (r_v_mem & ~mem_kill)
                                : (r_v_exe & ~w_stall_exe & ~exe_kill);
      w_v_wb_nxt  = r_v_mem & ~w_stall_mem & ~mem_kill;
      if (w_flush) begin
         w_v_if2_nxt = 1'b0;
         w_v_id_nxt  = 1'b0;
         w_v_exe_nxt = 1'b0;
         w_v_mem_nxt = 1'b0;
         w_v_wb_nxt  = 1'b0;
      end
   end

   // NOTE: reset is synchronous and this block holds only control flops, so all of them are reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_v_if2     <= 1'b0;
         r_v_id      <= 1'b0;
         r_v_exe     <= 1'b0;
         r_v_mem     <= 1'b0;
         r_v_wb      <= 1'b0;
         r_stall_cnt <= '0;
      end else begin
         r_v_if2 <= w_v_if2_nxt;
         r_v_id  <= w_v_id_nxt;
         r_v_exe <= w_v_exe_nxt;
         r_v_mem <= w_v_mem_nxt;
         r_v_wb  <= w_v_wb_nxt;
         if ((r_state == S_RUN) && w_stall_id && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign v_if2         = r_v_if2;
   assign v_id          = r_v_id;
   assign v_exe         = r_v_exe;
   assign v_mem         = r_v_mem;
   assign v_wb          = r_v_wb;
   assign trap_redirect = r_trap_redirect;
   assign state         = r_state;
   assign stall_cnt     = r_stall_cnt;

endmodule

// File: tb/tb_ysyx_041461_pipe_ctrl.sv
// Bench for ysyx_041461_pipe_ctrl: a hand-derived vector table checked through a scoreboard queue,
// a second 3-bit-counter instance for saturation, and a hand sequence for the trap pulse width.
module tb_ysyx_041461_pipe_ctrl;

   typedef struct {
      logic       rst;
      logic       mem_ready;
      logic [2:0] conf;    // {id, exe, mem}
      logic [4:0] kill;    // {if, if2, id, exe, mem}
      logic       redir;
      logic       commit;
      logic       chk_en;
      logic [4:0] en;      // {if, if2, id, exe, mem}, before the edge
      logic [4:0] v;       // {if2, id, exe, mem, wb}, after the edge
      logic [1:0] st;
      logic       trap;
      int         cnt;
   } vec_t;

   typedef struct {
      int         idx;
      logic [4:0] v;
      logic [1:0] st;
      logic       trap;
      int         cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic if_ready = 1'b1, mem_ready = 1'b1;
   logic id_conflict = 1'b0, exe_conflict = 1'b0, mem_conflict = 1'b0;
   logic if_kill = 1'b0, if2_kill = 1'b0, id_kill = 1'b0, exe_kill = 1'b0, mem_kill = 1'b0;
   logic id_redirect = 1'b0, wb_trap_commit = 1'b0;

   logic        v_if2, v_id, v_exe, v_mem, v_wb;
   logic        en_if, en_if2, en_id, en_exe, en_mem;
   logic        trap_redirect;
   logic [1:0]  state;
   logic [31:0] stall_cnt;

   logic        s_v_if2, s_v_id, s_v_exe, s_v_mem, s_v_wb;
   logic        s_en_if, s_en_if2, s_en_id, s_en_exe, s_en_mem;
   logic        s_trap_redirect;
   logic [1:0]  s_state;
   logic [2:0]  s_stall_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   vec_t vecs[$];
   exp_t sb[$];

   always #5 clk = ~clk;

   ysyx_041461_pipe_ctrl #(.CNT_W(32)) dut (
      .clk(clk), .rst(rst), .if_ready(if_ready), .mem_ready(mem_ready),
      .id_conflict(id_conflict), .exe_conflict(exe_conflict), .mem_conflict(mem_conflict),
      .if_kill(if_kill), .if2_kill(if2_kill), .id_kill(id_kill), .exe_kill(exe_kill),
      .mem_kill(mem_kill), .id_redirect(id_redirect), .wb_trap_commit(wb_trap_commit),
      .v_if2(v_if2), .v_id(v_id), .v_exe(v_exe), .v_mem(v_mem), .v_wb(v_wb),
      .en_if(en_if), .en_if2(en_if2), .en_id(en_id), .en_exe(en_exe), .en_mem(en_mem),
      .trap_redirect(trap_redirect), .state(state), .stall_cnt(stall_cnt)
   );

   ysyx_041461_pipe_ctrl #(.CNT_W(3)) dut_sat (
      .clk(clk), .rst(rst), .if_ready(if_ready), .mem_ready(mem_ready),
      .id_conflict(id_conflict), .exe_conflict(exe_conflict), .mem_conflict(mem_conflict),
      .if_kill(if_kill), .if2_kill(if2_kill), .id_kill(id_kill), .exe_kill(exe_kill),
      .mem_kill(mem_kill), .id_redirect(id_redirect), .wb_trap_commit(wb_trap_commit),
      .v_if2(s_v_if2), .v_id(s_v_id), .v_exe(s_v_exe), .v_mem(s_v_mem), .v_wb(s_v_wb),
      .en_if(s_en_if), .en_if2(s_en_if2), .en_id(s_en_id), .en_exe(s_en_exe), .en_mem(s_en_mem),
      .trap_redirect(s_trap_redirect), .state(s_state), .stall_cnt(s_stall_cnt)
   );

   task automatic check(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @vec %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic mrdy, input logic [2:0] conf,
                      input logic [4:0] kill, input logic redir, input logic commit,
                      input logic chk, input logic [4:0] en, input logic [4:0] v,
                      input logic [1:0] st, input logic trap, input int cnt);
      vec_t t;
      t.rst = r; t.mem_ready = mrdy; t.conf = conf; t.kill = kill; t.redir = redir;
      t.commit = commit; t.chk_en = chk; t.en = en; t.v = v; t.st = st; t.trap = trap;
      t.cnt = cnt;
      vecs.push_back(t);
   endtask

   task automatic drive(input logic r, input logic mrdy, input logic [2:0] conf,
                        input logic [4:0] kill, input logic redir, input logic commit);
      rst = r; mem_ready = mrdy;
      {id_conflict, exe_conflict, mem_conflict} = conf;
      {if_kill, if2_kill, id_kill, exe_kill, mem_kill} = kill;
      id_redirect = redir; wb_trap_commit = commit;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      exp_t e;
      int   pulses;

      // reset, then steady flow
      add(1, 1, 3'b000, 5'b00000, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0);
      add(1, 1, 3'b000, 5'b00000, 0, 0, 1, 5'b11111, 5'b00000, 0, 0, 0);
      add(0, 1, 3'b000, 5'b00000, 0, 0, 1, 5'b11111, 5'b10000, 0, 0, 0);
      add(0, 1, 3'b000, 5'b00000, 0, 0, 1, 5'b11111, 5'b11000, 0, 0, 0);
      add(0, 1, 3'b000, 5'b00000, 0, 0, 1, 5'b11111, 5'b11100, 0, 0, 0);
      add(0, 1, 3'b000, 5'b00000, 0, 0, 1, 5'b11111, 5'b11110, 0, 0, 0);
      add(0, 1, 3'b000, 5'b00000, 0, 0, 1, 5'b11111, 5'b11111, 0, 0, 0);
      // load-use: two bubbles into EXE
      add(0, 1, 3'b100, 5'b00000, 0, 0, 1, 5'b00011, 5'b11011, 0, 0, 1);
      add(0, 1, 3'b100, 5'b00000, 0, 0, 1, 5'b00011, 5'b11001, 0, 0, 2);
      add(0, 1, 3'b000, 5'b00000, 0, 0, 1, 5'b11111, 5'b11100, 0, 0, 2);
      add(0, 1, 3'b000, 5'b00000, 0, 0, 1, 5'b11111, 5'b11110, 0, 0, 2);
      add(0, 1, 3'b000, 5'b00000, 0, 0, 1, 5'b11111, 5'b11111, 0, 0, 2);
      // MEM busy three cycles
      add(0, 0, 3'b000, 5'b00000, 0, 0, 1, 5'b00000, 5'b11110, 0, 0, 3);
      add(0, 0, 3'b000, 5'b00000, 0, 0, 1, 5'b00000, 5'b11110, 0, 0, 4);
      add(0, 0, 3'b000, 5'b00000, 0, 0, 1, 5'b00000, 5'b11110, 0, 0, 5);
      add(0, 1, 3'b000, 5'b00000, 0, 0, 1, 5'b11111, 5'b11111, 0, 0, 5);
      // taken branch, then a redirect request with v_id=0 that must be ignored
      add(0, 1, 3'b000, 5'b00000, 1, 0, 1, 5'b11111, 5'b00111, 0, 0, 5);
      add(0, 1, 3'b000, 5'b00000, 1, 0, 1, 5'b11111, 5'b10011, 0, 0, 5);
      add(0, 1, 3'b000, 5'b00000, 0, 0, 1, 5'b11111, 5'b11001, 0, 0, 5);
      add(0, 1, 3'b000, 5'b00000, 0, 0, 1, 5'b11111, 5'b11100, 0, 0, 5);
      add(0, 1, 3'b000, 5'b00000, 0, 0, 1, 5'b11111, 5'b11110, 0, 0, 5);
      add(0, 1, 3'b000, 5'b00000, 0, 0, 1, 5'b11111, 5'b11111, 0, 0, 5);
      // EXE trap draining to WB
      add(0, 1, 3'b000, 5'b11100, 0, 0, 1, 5'b01111, 5'b00011, 1, 0, 5);
      add(0, 1, 3'b000, 5'b11110, 0, 0, 1, 5'b01111, 5'b00001, 1, 0, 5);
      add(0, 1, 3'b000, 5'b11111, 0, 1, 1, 5'b01111, 5'b00000, 2, 1, 5);
      add(0, 1, 3'b000, 5'b00000, 0, 0, 1, 5'b01111, 5'b00000, 0, 0, 5);
      add(0, 1, 3'b000, 5'b00000, 0, 0, 1, 5'b11111, 5'b10000, 0, 0, 5);
      // trap enters and commits together: RUN straight to REDIRECT, then flush
      add(0, 1, 3'b000, 5'b10000, 0, 1, 1, 5'b01111, 5'b01000, 2, 1, 5);
      add(0, 1, 3'b000, 5'b00000, 0, 0, 1, 5'b01111, 5'b00000, 0, 0, 5);
      add(0, 1, 3'b000, 5'b00000, 0, 0, 1, 5'b11111, 5'b10000, 0, 0, 5);
      add(0, 1, 3'b000, 5'b00000, 0, 0, 1, 5'b11111, 5'b11000, 0, 0, 5);
      add(0, 1, 3'b000, 5'b00000, 0, 0, 1, 5'b11111, 5'b11100, 0, 0, 5);
      add(0, 1, 3'b000, 5'b00000, 0, 0, 1, 5'b11111, 5'b11110, 0, 0, 5);
      // kill beats stall in a busy MEM
      add(0, 0, 3'b000, 5'b00001, 0, 0, 1, 5'b00000, 5'b11100, 0, 0, 6);
      add(0, 0, 3'b000, 5'b00000, 0, 0, 1, 5'b11111, 5'b11110, 0, 0, 6);
      // redirect and trap together, then an EXE stall in DRAIN (not counted)
      add(0, 1, 3'b000, 5'b10000, 1, 0, 1, 5'b01111, 5'b00111, 1, 0, 6);
      add(0, 1, 3'b010, 5'b00000, 0, 0, 1, 5'b00001, 5'b00101, 1, 0, 6);
      // reset in DRAIN, then reset in REDIRECT
      add(1, 1, 3'b000, 5'b00000, 0, 0, 1, 5'b01111, 5'b00000, 0, 0, 0);
      add(0, 1, 3'b000, 5'b10000, 0, 1, 1, 5'b01111, 5'b00000, 2, 1, 0);
      add(1, 1, 3'b000, 5'b00000, 0, 0, 1, 5'b01111, 5'b00000, 0, 0, 0);
      // long ID stall: the 3-bit counter saturates at 7
      add(0, 1, 3'b000, 5'b00000, 0, 0, 1, 5'b11111, 5'b10000, 0, 0, 0);
      add(0, 1, 3'b000, 5'b00000, 0, 0, 1, 5'b11111, 5'b11000, 0, 0, 0);
      for (int k = 1; k <= 10; k++)
         add(0, 1, 3'b100, 5'b00000, 0, 0, 1, 5'b00011, 5'b11000, 0, 0, k);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i].rst, vecs[i].mem_ready, vecs[i].conf, vecs[i].kill,
               vecs[i].redir, vecs[i].commit);
         #1;
         if (vecs[i].chk_en)
            check("en", i, 32'({en_if, en_if2, en_id, en_exe, en_mem}), 32'(vecs[i].en));
         e.idx = i; e.v = vecs[i].v; e.st = vecs[i].st; e.trap = vecs[i].trap;
         e.cnt = vecs[i].cnt;
         sb.push_back(e);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         check("valid", e.idx, 32'({v_if2, v_id, v_exe, v_mem, v_wb}), 32'(e.v));
         check("state", e.idx, 32'(state), 32'(e.st));
         check("trap_redirect", e.idx, 32'(trap_redirect), 32'(e.trap));
         check("stall_cnt", e.idx, stall_cnt, 32'(e.cnt));
         check("stall_cnt_sat", e.idx, 32'(s_stall_cnt), 32'((e.cnt > 7) ? 7 : e.cnt));
      end

      // Trap pulse width: one trap_redirect cycle, then back to RUN with fetch re-enabled.
      @(negedge clk);
      drive(1, 1, 3'b000, 5'b00000, 0, 0);
      @(negedge clk);
      drive(0, 1, 3'b000, 5'b10000, 0, 0);
      @(negedge clk);
      drive(0, 1, 3'b000, 5'b00000, 0, 1);
      #1;
      check("seq_state_drain", 100, 32'(state), 32'd1);
      check("seq_en_if_drain", 100, 32'(en_if), 32'd0);
      pulses = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         drive(0, 1, 3'b000, 5'b00000, 0, 0);
         if (trap_redirect) pulses++;
      end
      #1;
      check("seq_pulse_count", 101, 32'(pulses), 32'd1);
      check("seq_state_run", 101, 32'(state), 32'd0);
      check("seq_en_if_run", 101, 32'(en_if), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
